writeback_stage: RTL
====================

Name: writeback_stage

Overview:
- Final (fifth) pipeline stage, directly downstream of the memory stage.
- Consumes the memory stage's registered outputs and selects the write-back value: ALU result or load data.
- Drives a single registered write port into the decode stage's register file, plus the matching scoreboard-release strobe.
- Keeps retire, branch and stall statistics, and raises a sticky hang flag when the pipeline stalls continuously for too long.

Parameters:
- REG_WIDTH, 16, data/register width.
- OPCODE_WIDTH, 8, opcode width.
- CNT_WIDTH, 16, width of each statistics counter.
- STALL_LIMIT, 255, consecutive stalled cycles that set O_Hang.

Ports:
- I_CLOCK  in  1  pipeline clock; all state changes on its falling edge, matching the other stages.
- I_RESET_N  in  1  reset, asynchronous and active-low.
- I_LOCK  in  1  pipeline enable from the memory stage.
- I_ALUOut  in  REG_WIDTH  ALU/link result.
- I_MemOut  in  REG_WIDTH  load data.
- I_Opcode  in  OPCODE_WIDTH  opcode of the instruction in this stage.
- I_DestRegIdx  in  4  destination register index.
- I_FetchStall  in  1  bubble flag (fetch stall).
- I_DepStall  in  1  bubble flag (dependency stall).
- O_LOCK  out  1  registered copy of I_LOCK.
- O_WBEnable  out  1  register-file write strobe, one cycle per write.
- O_WBRegIdx  out  4  write index.
- O_WBData  out  REG_WIDTH  write data.
- O_RetireCount  out  CNT_WIDTH  instructions retired.
- O_BranchCount  out  CNT_WIDTH  branch/jump instructions retired.
- O_StallCount  out  CNT_WIDTH  bubble cycles seen while locked.
- O_Hang  out  1  sticky: stall run reached STALL_LIMIT.

Behaviour:
- Reset (I_RESET_N=0, asynchronous): every output and internal register goes to 0, FSM goes to ST_IDLE. Holds while asserted.
- Clock edge: all sequential logic updates on negedge I_CLOCK. Every output is registered.
- Valid instruction: I_LOCK=1, I_FetchStall=0 and I_DepStall=0. The memory stage holds stale opcode/index during stalls, so stalled cycles must never write or retire.
- FSM, two states:
  - ST_IDLE: entered from reset, or whenever I_LOCK=0. Outputs O_WBEnable=0; stall run counter cleared; statistics held.
  - ST_RUN: entered on the first edge with I_LOCK=1. Returns to ST_IDLE on the edge where I_LOCK=0.
  - O_LOCK follows I_LOCK with one edge of delay in both states.
- Write-back selection, on a valid edge in ST_RUN (or on the entry edge):
  - ADD_D, ADDI_D, AND_D, ANDI_D, MOV, MOVI_D, JSR, JSRR: O_WBEnable=1, O_WBData=I_ALUOut, O_WBRegIdx=I_DestRegIdx.
  - LDW: O_WBEnable=1, O_WBData=I_MemOut, O_WBRegIdx=I_DestRegIdx.
  - STW, BRN..BRNZP, JMP and any undefined opcode: O_WBEnable=0; O_WBData and O_WBRegIdx hold their previous values.
- Strobe timing:
  - Latency: one falling edge from input to strobe.
  - O_WBEnable is a single-cycle pulse; it deasserts on the next edge unless another writing instruction is valid.
  - Back-to-back writes to the same index each produce their own pulse.
- Retire counter: +1 on every valid edge, whatever the opcode.
- Branch counter: +1 on valid BRN..BRNZP, JMP, JSR, JSRR.
- Stall counter:
  - +1 on each edge with I_LOCK=1 and either stall flag set.
  - Both flags set in the same cycle still counts once.
- Counter width rule: all three counters saturate at all-ones and never wrap.
- Stall run counter (internal, 8+ bits):
  - Increments on stalled locked edges and clears on valid edges or when I_LOCK=0.
  - When it reaches STALL_LIMIT, O_Hang sets on that edge and stays set until reset.
  - The run counter itself saturates at STALL_LIMIT.
- Lock drop mid-instruction: nothing is written on that edge, and statistics are retained.
- Reset mid-write: the pending O_WBEnable pulse is cleared immediately (asynchronous).

Test Plan:
- Reset, then I_LOCK=1, valid ADD_D with I_ALUOut=16'h0042 and I_DestRegIdx=3 -> after one negedge: O_WBEnable=1, O_WBRegIdx=3, O_WBData=16'h0042, O_RetireCount=1. Next edge with no write -> O_WBEnable=0.
- Valid LDW with I_MemOut=16'hBEEF, I_ALUOut=16'h1234, idx=7 -> O_WBData=16'hBEEF, O_WBRegIdx=7. Then a valid STW -> O_WBEnable=0, O_RetireCount=2, O_WBData still 16'hBEEF.
- ADD_D held on the inputs with I_DepStall=1 for 3 cycles, then released -> exactly one write pulse, O_StallCount=3, O_RetireCount=1.
- Sequence BRZ, JMP, JSR (I_ALUOut=16'h0010, idx=7) -> O_BranchCount=3, O_RetireCount=3, exactly one write (idx=7, data 16'h0010).
- STALL_LIMIT=4, I_FetchStall=1 for 4 locked cycles -> O_Hang=1 on the 4th edge; it stays 1 after a valid instruction; only I_RESET_N=0 clears it.
- I_LOCK=0 for 2 cycles with ADD_D on the inputs -> no write, counters unchanged, O_LOCK=0. Assert I_RESET_N=0 between clock edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/writeback_stage.sv
// Final pipeline stage: picks the ALU or load result for the register-file write port
// and keeps saturating retire/branch/stall statistics plus a sticky pipeline-hang flag.
module writeback_stage #(
  parameter int REG_WIDTH    = 16,
  parameter int OPCODE_WIDTH = 8,
  parameter int CNT_WIDTH    = 16,
  parameter int STALL_LIMIT  = 255
) (
  input  logic                    I_CLOCK,
  input  logic                    I_RESET_N,
  input  logic                    I_LOCK,
  input  logic [REG_WIDTH-1:0]    I_ALUOut,
  input  logic [REG_WIDTH-1:0]    I_MemOut,
  input  logic [OPCODE_WIDTH-1:0] I_Opcode,
  input  logic [3:0]              I_DestRegIdx,
  input  logic                    I_FetchStall,
  input  logic                    I_DepStall,
  output logic                    O_LOCK,
  output logic                    O_WBEnable,
  output logic [3:0]              O_WBRegIdx,
  output logic [REG_WIDTH-1:0]    O_WBData,
  output logic [CNT_WIDTH-1:0]    O_RetireCount,
  output logic [CNT_WIDTH-1:0]    O_BranchCount,
  output logic [CNT_WIDTH-1:0]    O_StallCount,
  output logic                    O_Hang
);

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD_D  = OPCODE_WIDTH'(8'h00);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI_D = OPCODE_WIDTH'(8'h01);
  localparam logic [OPCODE_WIDTH-1:0] OP_AND_D  = OPCODE_WIDTH'(8'h02);
  localparam logic [OPCODE_WIDTH-1:0] OP_ANDI_D = OPCODE_WIDTH'(8'h03);
  localparam logic [OPCODE_WIDTH-1:0] OP_MOV    = OPCODE_WIDTH'(8'h04);
  localparam logic [OPCODE_WIDTH-1:0] OP_MOVI_D = OPCODE_WIDTH'(8'h05);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDW    = OPCODE_WIDTH'(8'h06);
  localparam logic [OPCODE_WIDTH-1:0] OP_STW    = OPCODE_WIDTH'(8'h07);
  localparam logic [OPCODE_WIDTH-1:0] OP_BRN    = OPCODE_WIDTH'(8'h08);
  localparam logic [OPCODE_WIDTH-1:0] OP_BRZ    = OPCODE_WIDTH'(8'h09);
  localparam logic [OPCODE_WIDTH-1:0] OP_BRP    = OPCODE_WIDTH'(8'h0A);
  localparam logic [OPCODE_WIDTH-1:0] OP_BRNZ   = OPCODE_WIDTH'(8'h0B);
  localparam logic [OPCODE_WIDTH-1:0] OP_BRNP   = OPCODE_WIDTH'(8'h0C);
  localparam logic [OPCODE_WIDTH-1:0] OP_BRZP   = OPCODE_WIDTH'(8'h0D);
  localparam logic [OPCODE_WIDTH-1:0] OP_BRNZP  = OPCODE_WIDTH'(8'h0E);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP    = OPCODE_WIDTH'(8'h0F);
  localparam logic [OPCODE_WIDTH-1:0] OP_JSR    = OPCODE_WIDTH'(8'h10);
  localparam logic [OPCODE_WIDTH-1:0] OP_JSRR   = OPCODE_WIDTH'(8'h11);

  localparam int RUN_W = ($clog2(STALL_LIMIT + 1) > 8) ? $clog2(STALL_LIMIT + 1) : 8;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STALL_LIMIT);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t           state;
  logic [RUN_W-1:0] run_p1;
  logic [RUN_W-1:0] run_nxt_p0;
  logic             vld_p0;
  logic             stall_p0;
  logic             wr_alu_p0;
  logic             wr_mem_p0;
  logic             is_br_p0;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [RUN_W-1:0] run_inc(input logic [RUN_W-1:0] v);
    return (v >= RUN_MAX) ? RUN_MAX : v + 1'b1;
  endfunction

  // Stage p0: qualify the held instruction and decode its write-back class
  always_comb begin
    vld_p0     = I_LOCK & ~I_FetchStall & ~I_DepStall;
    stall_p0   = I_LOCK & (I_FetchStall | I_DepStall);
    run_nxt_p0 = run_inc(run_p1);
    wr_alu_p0  = 1'b0;
    wr_mem_p0  = 1'b0;
    is_br_p0   = 1'b0;
    case (I_Opcode)
      OP_ADD_D, OP_ADDI_D, OP_AND_D, OP_ANDI_D, OP_MOV, OP_MOVI_D: wr_alu_p0 = 1'b1;
      OP_JSR, OP_JSRR: begin
        wr_alu_p0 = 1'b1;
        is_br_p0  = 1'b1;
      end
      OP_LDW: wr_mem_p0 = 1'b1;
      OP_BRN, OP_BRZ, OP_BRP, OP_BRNZ, OP_BRNP, OP_BRZP, OP_BRNZP, OP_JMP: is_br_p0 = 1'b1;
      OP_STW: wr_alu_p0 = 1'b0;
      default: wr_alu_p0 = 1'b0;
    endcase
  end

  // Stage p1: registered write port, statistics and hang detection
  always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state         <= ST_IDLE;
      run_p1        <= '0;
      O_LOCK        <= 1'b0;
      O_WBEnable    <= 1'b0;
      O_WBRegIdx    <= '0;
      O_WBData      <= '0;
      O_RetireCount <= '0;
      O_BranchCount <= '0;
      O_StallCount  <= '0;
      O_Hang        <= 1'b0;
    end else begin
      O_LOCK     <= I_LOCK;
      O_WBEnable <= 1'b0;
      case (state)
        ST_IDLE: if (I_LOCK) state <= ST_RUN;
        ST_RUN:  if (!I_LOCK) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      if (!I_LOCK) begin
        run_p1 <= '0;
      end else if (stall_p0) begin
        O_StallCount <= sat_inc(O_StallCount);
        run_p1       <= run_nxt_p0;
        if (run_nxt_p0 == RUN_MAX) O_Hang <= 1'b1;
      end else if (vld_p0) begin
        run_p1        <= '0;
        O_RetireCount <= sat_inc(O_RetireCount);
        if (is_br_p0) O_BranchCount <= sat_inc(O_BranchCount);
        if (wr_alu_p0 || wr_mem_p0) begin
          O_WBEnable <= 1'b1;
          O_WBRegIdx <= I_DestRegIdx;
          O_WBData   <= wr_mem_p0 ? I_MemOut : I_ALUOut;
        end
      end
    end
  end

endmodule
